// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampling UART receiver feeding a FWFT receive FIFO; define UART_RX_PARITY_EN for 8E1 frames
module uart_rx_fifo #(
  parameter int BAUD_RATE  = 9_600,
  parameter int CLOCK_RATE = 40_000_000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_clk_rx,
  input  logic       rxd_i,
  input  logic       rx_fifo_rd_en,
  output logic [7:0] rx_fifo_dout,
  output logic       rx_fifo_empty,
  output logic       rx_fifo_full,
  output logic       rx_frame_err,
  output logic       rx_parity_err,
  output logic       rx_overrun
);

  localparam int DIV_RAW = (CLOCK_RATE + BAUD_RATE * 8) / (BAUD_RATE * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic          rxd_m, rxd_s;
  logic [CW-1:0] baud_cnt;
  logic          tick;

  state_t        state, state_n;
  logic [3:0]    os, os_n;
  logic [2:0]    bi, bi_n;
  logic [7:0]    shreg, shreg_n;
  logic          lwh, lwh_n;
  logic          push_req, ferr_req;
  logic          push_q, ferr_q;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_n;
  logic          do_push, do_pop;

`ifdef UART_RX_PARITY_EN
  logic          par_bit, par_n;
  logic          perr_req, perr_q;
`endif

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst_clk_rx) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd_i;
      rxd_s <= rxd_m;
    end
  end

  // Free-running 16x baud tick divider
  assign tick = (baud_cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst_clk_rx || tick) baud_cnt <= '0;
    else                    baud_cnt <= baud_cnt + CW'(1);
  end

  // Receiver FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (rst_clk_rx) begin
      state <= S_IDLE;
      os    <= '0;
      bi    <= '0;
      shreg <= '0;
      lwh   <= 1'b1;
    end else begin
      state <= state_n;
      os    <= os_n;
      bi    <= bi_n;
      shreg <= shreg_n;
      lwh   <= lwh_n;
    end
  end

  // Next-state logic; every action is qualified by the baud tick
  always_comb begin
    state_n  = state;
    os_n     = os;
    bi_n     = bi;
    shreg_n  = shreg;
    lwh_n    = lwh;
    push_req = 1'b0;
    ferr_req = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n    = par_bit;
    perr_req = 1'b0;
`endif
    if (tick) begin
      if (rxd_s) lwh_n = 1'b1;
      case (state)
        S_IDLE: begin
          if (!rxd_s && lwh) begin
            state_n = S_START;
            os_n    = '0;
            lwh_n   = 1'b0;
          end
        end
        S_START: begin
          if (os == 4'd7) begin
            if (rxd_s) begin
              state_n = S_IDLE;
            end else begin
              state_n = S_DATA;
              os_n    = '0;
              bi_n    = '0;
            end
          end else begin
            os_n = os + 4'd1;
          end
        end
        S_DATA: begin
          if (os == 4'd15) begin
            shreg_n = {rxd_s, shreg[7:1]};
            os_n    = '0;
            bi_n    = bi + 3'd1;
            if (bi == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_n = S_PARITY;
`else
              state_n = S_STOP;
`endif
            end
          end else begin
            os_n = os + 4'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (os == 4'd15) begin
            par_n   = rxd_s;
            os_n    = '0;
            state_n = S_STOP;
          end else begin
            os_n = os + 4'd1;
          end
        end
`endif
        S_STOP: begin
          if (os == 4'd15) begin
            state_n = S_IDLE;
            if (!rxd_s) begin
              // A low stop bit may be the start of a break: demand a high sample before re-arming
              ferr_req = 1'b1;
              lwh_n    = 1'b0;
            end
`ifdef UART_RX_PARITY_EN
            else if (^{shreg, par_bit}) perr_req = 1'b1;
`endif
            else push_req = 1'b1;
          end else begin
            os_n = os + 4'd1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Push strobe and frame-error pulse, one cycle after the stop-bit sample
  always_ff @(posedge clk) begin
    if (rst_clk_rx) begin
      push_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      push_q <= push_req;
      ferr_q <= ferr_req;
    end
  end

  assign rx_frame_err = ferr_q;

`ifdef UART_RX_PARITY_EN
  // Captured parity bit and parity-error pulse
  always_ff @(posedge clk) begin
    if (rst_clk_rx) begin
      par_bit <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      par_bit <= par_n;
      perr_q  <= perr_req;
    end
  end

  assign rx_parity_err = perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif

  // A pop on the same cycle frees the slot, so a full FIFO can still accept
  assign do_pop     = rx_fifo_rd_en && !rx_fifo_empty;
  assign do_push    = push_q && (!rx_fifo_full || rx_fifo_rd_en);
  assign rx_overrun = push_q && rx_fifo_full && !rx_fifo_rd_en;

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_n = count;
    if (do_push && !do_pop)      count_n = count + (AW + 1)'(1);
    else if (!do_push && do_pop) count_n = count - (AW + 1)'(1);
  end

  // Receive buffer storage
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  // Pointers, occupancy and registered flags
  always_ff @(posedge clk) begin
    if (rst_clk_rx) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      rx_fifo_empty <= 1'b1;
      rx_fifo_full  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count         <= count_n;
      rx_fifo_empty <= (count_n == '0);
      rx_fifo_full  <= (count_n == (AW + 1)'(FIFO_DEPTH));
    end
  end

  assign rx_fifo_dout = rx_fifo_empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized self-checking bench for uart_rx_fifo against a frame-level reference model
module tb_uart_rx_fifo;

  localparam int CLOCK_RATE = 40_000_000;
  localparam int BAUD_RATE  = 625_000;
  localparam int FIFO_DEPTH = 16;
  localparam int DIV        = 4;
  localparam int BIT        = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_EN     = 1;
`else
  localparam int PAR_EN     = 0;
`endif
  // Ticks from start detection to stop-bit sample: half a bit, then data (+parity) and stop bits
  localparam int STOP_TICKS = 8 + 16 * (9 + PAR_EN);
  localparam int K_PUSH = 0, K_FERR = 1, K_PERR = 2;

  typedef struct {
    int         at;
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_clk_rx, rxd_i, rd_main, rd_r, rd_rand;
  logic       rx_fifo_rd_en;
  logic [7:0] rx_fifo_dout;
  logic       rx_fifo_empty, rx_fifo_full, rx_frame_err, rx_parity_err, rx_overrun;

  int         cyc = 0;
  int         rst_base = 0;
  int         rd_div = 3000;
  bit         armed = 1'b0;
  int         n_cmp = 0, n_bad = 0;
  int         seen_ferr = 0, seen_perr = 0, seen_ovr = 0;
  ev_t        evq[$];
  logic [7:0] mq[$];

  assign rx_fifo_rd_en = rd_main | rd_r;

  uart_rx_fifo #(
    .BAUD_RATE (BAUD_RATE),
    .CLOCK_RATE(CLOCK_RATE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_clk_rx   (rst_clk_rx),
    .rxd_i        (rxd_i),
    .rx_fifo_rd_en(rx_fifo_rd_en),
    .rx_fifo_dout (rx_fifo_dout),
    .rx_fifo_empty(rx_fifo_empty),
    .rx_fifo_full (rx_fifo_full),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err),
    .rx_overrun   (rx_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue, frames as scheduled outcome events
  always @(negedge clk) begin
    bit   has_ev, pop, exp_ovr, exp_ferr, exp_perr;
    ev_t  ev;
    has_ev = (evq.size() > 0) && (evq[0].at == cyc);
    if (has_ev) ev = evq.pop_front();
    exp_ferr = has_ev && (ev.kind == K_FERR);
    exp_perr = has_ev && (ev.kind == K_PERR);
    exp_ovr  = has_ev && (ev.kind == K_PUSH) && (mq.size() == FIFO_DEPTH) && !rx_fifo_rd_en;
    if (armed) begin
      check("empty", rx_fifo_empty, mq.size() == 0);
      check("full", rx_fifo_full, mq.size() == FIFO_DEPTH);
      if (mq.size() > 0) check("dout", rx_fifo_dout, mq[0]);
      check("frame_err", rx_frame_err, exp_ferr);
      check("parity_err", rx_parity_err, exp_perr);
      check("overrun", rx_overrun, exp_ovr);
    end
    if (rx_frame_err === 1'b1)  seen_ferr++;
    if (rx_parity_err === 1'b1) seen_perr++;
    if (rx_overrun === 1'b1)    seen_ovr++;
    pop = rx_fifo_rd_en && (mq.size() > 0);
    if (pop) void'(mq.pop_front());
    if (has_ev && ev.kind == K_PUSH && !exp_ovr) mq.push_back(ev.data);
    if (rst_clk_rx) begin
      mq.delete();
      evq.delete();
      rst_base = cyc + 1;
      armed    = 1'b1;
    end
  end

  // Background random reader
  initial begin
    rd_r = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rd_r = rd_rand && ($urandom_range(0, rd_div - 1) == 0);
    end
  end

  task automatic idle(input int bits);
    rxd_i = 1'b1;
    repeat (bits * BIT) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rxd_i = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  // Schedules the outcome at stop-sample + 1, then drives the frame
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par);
    int  m;
    ev_t ev;
    m = cyc + 2;
    while (((m - rst_base) % DIV) != DIV - 1) m++;
    ev.at   = m + STOP_TICKS * DIV + 1;
    ev.data = data;
    if (!stop)                            ev.kind = K_FERR;
    else if (PAR_EN == 1 && (^data ^ par)) ev.kind = K_PERR;
    else                                  ev.kind = K_PUSH;
    evq.push_back(ev);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if (PAR_EN == 1) drive_bit(par);
    drive_bit(stop);
  endtask

  task automatic good(input logic [7:0] data);
    send_frame(data, 1'b1, ^data);
  endtask

  task automatic pop_one();
    rd_main = 1'b1;
    @(posedge clk);
    #1;
    rd_main = 1'b0;
  endtask

  initial begin
    int         base, f0, o0;
    logic [7:0] d;
    logic       stop, par;
    rxd_i      = 1'b1;
    rd_main    = 1'b0;
    rd_rand    = 1'b0;
    rst_clk_rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_clk_rx = 1'b0;
    @(posedge clk);
    #1;
    check("reset_empty", rx_fifo_empty, 1);
    check("reset_full", rx_fifo_full, 0);
    check("reset_dout", rx_fifo_dout, 8'h00);
    check("reset_pulses", {rx_frame_err, rx_parity_err, rx_overrun}, 3'b000);
    idle(2);

    // Single clean character
    good(8'h55);
    idle(1);
    check("t1_empty", rx_fifo_empty, 0);
    check("t1_dout", rx_fifo_dout, 8'h55);
    pop_one();
    check("t1_empty_after_pop", rx_fifo_empty, 1);

    // Short low glitch is rejected
    base = seen_ferr + seen_perr + seen_ovr;
    rxd_i = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    idle(3);
    check("t2_empty", rx_fifo_empty, 1);
    check("t2_no_pulses", seen_ferr + seen_perr + seen_ovr - base, 0);

    // Framing error followed by a break
    f0 = seen_ferr;
    d  = 8'hA5;
    send_frame(d, 1'b0, ^d);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    idle(3);
    check("t3_ferr_count", seen_ferr - f0, 1);
    check("t3_empty", rx_fifo_empty, 1);

    // Fill to full and overrun on the 17th character
    o0 = seen_ovr;
    for (int i = 0; i < 17; i++) begin
      good(8'(i));
      if (i == 15) check("t4_full", rx_fifo_full, 1);
    end
    idle(1);
    check("t4_overrun_count", seen_ovr - o0, 1);
    for (int i = 0; i < 16; i++) begin
      check("t4_read", rx_fifo_dout, 8'(i));
      pop_one();
    end
    check("t4_empty", rx_fifo_empty, 1);

    // Reset mid-character discards the partial byte and the FIFO
    good(8'h11);
    idle(1);
    d = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rxd_i      = 1'b1;
    rst_clk_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_clk_rx = 1'b0;
    check("t5_empty_after_reset", rx_fifo_empty, 1);
    idle(2);
    good(8'h81);
    idle(1);
    check("t5_dout", rx_fifo_dout, 8'h81);
    pop_one();
    check("t5_empty", rx_fifo_empty, 1);

`ifdef UART_RX_PARITY_EN
    // Parity error drops the byte, correct parity pushes it
    f0 = seen_perr;
    send_frame(8'h03, 1'b1, 1'b1);
    idle(1);
    check("t6_perr_count", seen_perr - f0, 1);
    check("t6_empty", rx_fifo_empty, 1);
    send_frame(8'h03, 1'b1, 1'b0);
    idle(1);
    check("t6_dout", rx_fifo_dout, 8'h03);
    pop_one();
`endif

    // Random traffic: slow reader first so the FIFO fills, then a fast reader
    rd_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 25) rd_div = 150;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      par  = (^d) ^ ($urandom_range(0, 7) == 0);
      send_frame(d, stop, par);
      idle(1 + $urandom_range(0, 1));
    end
    rd_rand = 1'b0;
    idle(1);
    repeat (FIFO_DEPTH + 1) pop_one();
    idle(1);
    check("final_empty", rx_fifo_empty, 1);
    check("final_events_consumed", evq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
